// File: rtl/rotary_input_decoder.sv
// rotary_input_decoder
//   Front end for a quadrature rotary encoder with a push button. The raw pins are
//   synchronised into the clk domain. Detents become single-cycle right/left
//   pulses. A bounded position counter with preload tracks the encoder. The button
//   is debounced into held/press/release/long-press events. Every output is
//   registered.
//
// Ports
//   clk_i          system clock (single domain)
//   reset_i        synchronous, active-high reset
//   rotA_i/rotB_i  quadrature pins, asynchronous
//   rotCenter_i    push-button pin, active high, asynchronous
//   load_i         load position from load_value_i (wins over a same-cycle step)
//   load_value_i   preset value for position
//   right_o        one-cycle pulse per clockwise detent
//   left_o         one-cycle pulse per counter-clockwise detent
//   position_o     current encoder position
//   held_o         level, debounced button down
//   press_o        one-cycle pulse when held_o rises
//   release_o      one-cycle pulse when held_o falls
//   long_press_o   one-cycle pulse, at most once per press
module rotary_input_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4095,
    parameter int unsigned LONG_PRESS_CYCLES = 25_000_000,
    parameter int unsigned POS_WIDTH         = 8,
    parameter bit          WRAP              = 1'b1,
    parameter int unsigned RESET_POS         = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rotA_i,
    input  logic                 rotB_i,
    input  logic                 rotCenter_i,
    input  logic                 load_i,
    input  logic [POS_WIDTH-1:0] load_value_i,
    output logic                 right_o,
    output logic                 left_o,
    output logic [POS_WIDTH-1:0] position_o,
    output logic                 held_o,
    output logic                 press_o,
    output logic                 release_o,
    output logic                 long_press_o
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LPW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DBW-1:0]       DB_MAX   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0]       DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LPW-1:0]       LP_MAX   = LPW'(LONG_PRESS_CYCLES);
    localparam logic [LPW-1:0]       LP_LAST  = LPW'(LONG_PRESS_CYCLES - 1);
    localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0] POS_TOP  = {POS_WIDTH{1'b1}};
    localparam logic [POS_WIDTH-1:0] POS_RST  = POS_WIDTH'(RESET_POS);

    // Two-flop synchronisers
    logic a_meta_q, a_s_q, b_meta_q, b_s_q, btn_meta_q, btn_s_q;

    // Detent filter and step generation
    logic           q1_q, q1_d, q2_q, q2_d, q1_dly_q;
    logic [1:0]     fill_q, fill_d;
    logic           armed_q, armed_d;
    logic           step;
    logic           right_q, right_d, left_q, left_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    // Button
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [LPW-1:0] lp_cnt_q, lp_cnt_d;
    logic           held_q, held_d, press_q, press_d;
    logic           release_q, release_d, long_q, long_d;

    always_comb begin
        q1_d   = q1_q;
        q2_d   = q2_q;
        unique case ({b_s_q, a_s_q})
            2'b00: q1_d = 1'b0;
            2'b11: q1_d = 1'b1;
            2'b01: q2_d = 1'b0;
            default: q2_d = 1'b1;
        endcase

        // fill_q reaches 3 once q1 holds a value derived from real pin samples
        // rather than the reset contents of the synchronisers. Arming only on a
        // genuine q1==0 keeps pins resting at 11 through reset from being
        // mistaken for a fresh detent.
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        armed_d = armed_q | ((fill_q == 2'd3) & ~q1_q);

        step    = armed_q & q1_q & ~q1_dly_q;
        right_d = step & q2_q;
        left_d  = step & ~q2_q;

        pos_d = pos_q;
        if (load_i) begin
            pos_d = load_value_i;
        end else if (right_d) begin
            if (WRAP || pos_q != POS_TOP) pos_d = pos_q + POS_ONE;
        end else if (left_d) begin
            if (WRAP || pos_q != '0) pos_d = pos_q - POS_ONE;
        end
    end

    always_comb begin
        db_cnt_d  = db_cnt_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (!btn_s_q) begin
            db_cnt_d = '0;
            if (held_q) begin
                held_d    = 1'b0;
                release_d = 1'b1;
            end
        end else begin
            if (db_cnt_q != DB_MAX) db_cnt_d = db_cnt_q + 1'b1;
            // Count is about to reach the threshold on this edge.
            if (db_cnt_q == DB_LAST) begin
                held_d  = 1'b1;
                press_d = 1'b1;
            end
        end

        // Long-press counter runs only while held and the pin is still high;
        // the cycle that drops held clears it.
        lp_cnt_d = '0;
        long_d   = 1'b0;
        if (held_q && btn_s_q) begin
            lp_cnt_d = (lp_cnt_q != LP_MAX) ? lp_cnt_q + 1'b1 : lp_cnt_q;
            long_d   = (lp_cnt_q == LP_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_meta_q   <= 1'b0;
            a_s_q      <= 1'b0;
            b_meta_q   <= 1'b0;
            b_s_q      <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            q1_q       <= 1'b0;
            q2_q       <= 1'b0;
            q1_dly_q   <= 1'b0;
            fill_q     <= 2'd0;
            armed_q    <= 1'b0;
            right_q    <= 1'b0;
            left_q     <= 1'b0;
            pos_q      <= POS_RST;
            db_cnt_q   <= '0;
            lp_cnt_q   <= '0;
            held_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            a_meta_q   <= rotA_i;
            a_s_q      <= a_meta_q;
            b_meta_q   <= rotB_i;
            b_s_q      <= b_meta_q;
            btn_meta_q <= rotCenter_i;
            btn_s_q    <= btn_meta_q;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            q1_dly_q   <= q1_q;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            right_q    <= right_d;
            left_q     <= left_d;
            pos_q      <= pos_d;
            db_cnt_q   <= db_cnt_d;
            lp_cnt_q   <= lp_cnt_d;
            held_q     <= held_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign right_o      = right_q;
    assign left_o       = left_q;
    assign position_o   = pos_q;
    assign held_o       = held_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule
